wb_bus_arbiter: RTL and testbench
=================================

# wb_bus_arbiter

Four-master Wishbone arbiter that shares the single monitor-controller slave bus among its masters. Requests are granted in round-robin order, one transaction at a time. Each access is checked against an address limit, and every slave access is watched for a timeout. The block drives the `bm_*` event outputs consumed by the bus-monitor register block, and it terminates faulted cycles itself so that no master ever hangs.

## Interface
Parameters:
- `TIMEOUT_LIMIT`, default 1023: slave wait cycles tolerated; a 10-bit counter compares against it.
- `ADR_LIMIT`, default 16'hC000: first illegal address; any address ≥ `ADR_LIMIT` is a memory violation.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, synchronous, active-low.
- `wbm_cyc_i` in 4: per-master cycle.
- `wbm_stb_i` in 4: per-master strobe.
- `wbm_we_i` in 4: per-master write enable.
- `wbm_adr_i` in 64: 4×16 addresses; master n occupies bits [16n+15:16n].
- `wbm_dat_i` in 64: 4×16 write data, same packing as `wbm_adr_i`.
- `wbm_dat_o` out 16: read data, shared by all masters, qualified by ack.
- `wbm_ack_o` out 4: per-master ack.
- `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o` out 1 each: slave control.
- `wbs_adr_o` out 16, `wbs_dat_o` out 16: slave address and write data.
- `wbs_dat_i` in 16, `wbs_ack_i` in 1: slave read data and ack.
- `bm_memv` out 1, `bm_timeout` out 1: one-cycle event pulses.
- `bm_wbm_id` out 2, `bm_addr` out 16, `bm_we` out 1: identify the faulting transaction; valid while either pulse is high.

## Operation
- FSM states:
  - IDLE: sample requests (`wbm_cyc_i & wbm_stb_i`). If any request is present, pick the winner round-robin, searching from `last_grant+1`. Latch its id, adr, we and dat, and set `last_grant` to its id. Go to MEMV if adr ≥ `ADR_LIMIT`, otherwise to ACCESS. With no request, stay in IDLE.
  - ACCESS: `wbs_cyc_o`/`wbs_stb_o` high, with latched adr/we/dat on the slave bus. The wait counter starts at 0 and increments each cycle.
    - `wbs_ack_i` → capture `wbs_dat_i`, go to RESP.
    - Otherwise, counter == `TIMEOUT_LIMIT` → go to TOUT.
    - Ack on the limit cycle wins over timeout.
  - RESP: `wbm_ack_o[id]`=1 and `wbm_dat_o`=captured data for one cycle; then IDLE.
  - MEMV: `wbm_ack_o[id]`=1, `wbm_dat_o`=0, `bm_memv`=1; then IDLE. The slave bus is never driven.
  - TOUT: `wbm_ack_o[id]`=1, `wbm_dat_o`=0, `bm_timeout`=1, slave cyc/stb low; then IDLE.
- `bm_wbm_id`/`bm_addr`/`bm_we` carry the latched id/adr/we whenever in MEMV or TOUT; they are 0 otherwise.
- A master that drops `cyc` while in ACCESS is not aborted. The transaction completes or times out, and the ack is still issued.
- Only one grant is outstanding at any time. Non-granted masters see ack=0.

## Timing
- All outputs are registered. Reset values: all acks, slave controls and `bm_*` outputs are 0; `wbs_adr_o`/`wbs_dat_o`/`wbm_dat_o` are 0; state is IDLE; `last_grant`=3, so master 0 has priority first.
- Request sampled at edge 0:
  - Slave `stb` appears in cycle 1.
  - A slave ack in cycle k gives the master ack in cycle k+1.
  - Zero-wait slave: master ack in cycle 2.
- Memory violation: master ack and `bm_memv` in cycle 1.
- Timeout: ACCESS lasts `TIMEOUT_LIMIT`+1 cycles, then TOUT for one cycle.
- Back-to-back requests: there is a minimum of one IDLE cycle between grants.
- Reset asserted mid-transaction: state goes to IDLE at the next edge, and no ack or event is emitted for the aborted transaction.

## Configuration
- Macro `BUS_ARB_MEMV_EN`.
  - Defined: address check active, MEMV state reachable.
  - Undefined: every request goes to ACCESS, `bm_memv` is constant 0, and `ADR_LIMIT` is ignored.

## Structure
- Shared package/header `bus_arb_pkg` holds:
  - state encodings (IDLE, ACCESS, RESP, MEMV, TOUT);
  - `NUM_MASTERS`=4 and id width 2;
  - default `TIMEOUT_LIMIT` and `ADR_LIMIT`.
- Sub-module `rr_arbiter`: combinational 4-way round-robin pick. Inputs are the request vector and `last_grant`; outputs are a grant-valid flag and a 2-bit grant id.

## Test plan
- Master 2 reads 16'h0010; slave acks after 3 cycles with 16'hBEEF → `wbm_ack_o`=4'b0100 for one cycle, `wbm_dat_o`=16'hBEEF, no `bm_*` pulses.
- Masters 0–3 all request at once and continuously → grants in order 0,1,2,3,0, one IDLE cycle between grants.
- Master 1 writes 16'hC000 → ack in cycle 1, `bm_memv`=1, `bm_wbm_id`=1, `bm_addr`=16'hC000, `bm_we`=1, `wbs_cyc_o` never high. With the macro undefined, the access reaches the slave instead.
- Master 3 reads; slave never acks, `TIMEOUT_LIMIT`=8 → `wbs_stb_o` high for 9 cycles, then `bm_timeout`=1, `bm_wbm_id`=3, ack with data 0.
- Slave acks exactly on the limit cycle → normal RESP, no `bm_timeout`.
- `wb_rst_i` driven low during ACCESS → next edge: IDLE, all outputs 0, no ack; master 0 is granted first afterwards.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the four-master Wishbone bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned ID_W        = 2;

  localparam int unsigned DEF_TIMEOUT_LIMIT = 1023;
  localparam logic [15:0] DEF_ADR_LIMIT     = 16'hC000;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StResp,
    StMemv,
    StTout
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational 4-way round-robin pick, searching upward from last_grant + 1.
module rr_arbiter
  import bus_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        last_grant,
  output logic                   valid,
  output logic [ID_W-1:0]        id
);

  logic [ID_W-1:0] idx;

  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = last_grant + ID_W'(i);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Four-master Wishbone arbiter with slave timeout and optional address-limit check.
// Address check is compiled in only when BUS_ARB_MEMV_EN is defined.
module wb_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_LIMIT = DEF_TIMEOUT_LIMIT,
  parameter logic [15:0] ADR_LIMIT     = DEF_ADR_LIMIT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  wbm_cyc_i,
  input  logic [3:0]  wbm_stb_i,
  input  logic [3:0]  wbm_we_i,
  input  logic [63:0] wbm_adr_i,
  input  logic [63:0] wbm_dat_i,
  output logic [15:0] wbm_dat_o,
  output logic [3:0]  wbm_ack_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [15:0] wbs_adr_o,
  output logic [15:0] wbs_dat_o,
  input  logic [15:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  output logic        bm_memv,
  output logic        bm_timeout,
  output logic [1:0]  bm_wbm_id,
  output logic [15:0] bm_addr,
  output logic        bm_we
);

  localparam logic [9:0] TLIM = 10'(TIMEOUT_LIMIT);

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     adr_q, adr_d;
  logic            we_q, we_d;
  logic [15:0]     wdat_q, wdat_d;
  logic [15:0]     rdat_q, rdat_d;
  logic [9:0]      cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   gnt_valid;
  logic [ID_W-1:0]        gnt_id;
  logic [15:0]            sel_adr;
  logic                   memv_hit;

  logic [3:0]  ack_d;
  logic [15:0] mdat_d;
  logic        scyc_d;
  logic        swe_d;
  logic [15:0] sadr_d;
  logic [15:0] sdat_d;
  logic        memv_d;
  logic        tout_d;
  logic [1:0]  bid_d;
  logic [15:0] baddr_d;
  logic        bwe_d;

  assign req     = wbm_cyc_i & wbm_stb_i;
  assign sel_adr = wbm_adr_i[{gnt_id, 4'b0000} +: 16];

  rr_arbiter u_rr_arbiter (
    .req        (req),
    .last_grant (last_q),
    .valid      (gnt_valid),
    .id         (gnt_id)
  );

`ifdef BUS_ARB_MEMV_EN
  assign memv_hit = (sel_adr >= ADR_LIMIT);
`else
  logic unused_adr_limit;
  assign memv_hit         = 1'b0;
  assign unused_adr_limit = ^ADR_LIMIT;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          id_d    = gnt_id;
          last_d  = gnt_id;
          adr_d   = sel_adr;
          we_d    = wbm_we_i[gnt_id];
          wdat_d  = wbm_dat_i[{gnt_id, 4'b0000} +: 16];
          cnt_d   = '0;
          state_d = memv_hit ? StMemv : StAccess;
        end
      end
      StAccess: begin
        // Ack on the limit cycle takes priority over the timeout.
        if (wbs_ack_i) begin
          rdat_d  = wbs_dat_i;
          state_d = StResp;
        end else if (cnt_q == TLIM) begin
          state_d = StTout;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StResp, StMemv, StTout: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    ack_d   = '0;
    mdat_d  = '0;
    scyc_d  = 1'b0;
    swe_d   = 1'b0;
    sadr_d  = '0;
    sdat_d  = '0;
    memv_d  = 1'b0;
    tout_d  = 1'b0;
    bid_d   = '0;
    baddr_d = '0;
    bwe_d   = 1'b0;
    unique case (state_d)
      StAccess: begin
        scyc_d = 1'b1;
        swe_d  = we_d;
        sadr_d = adr_d;
        sdat_d = wdat_d;
      end
      StResp: begin
        ack_d[id_d] = 1'b1;
        mdat_d      = rdat_d;
      end
      StMemv, StTout: begin
        ack_d[id_d] = 1'b1;
        memv_d      = (state_d == StMemv);
        tout_d      = (state_d == StTout);
        bid_d       = id_d;
        baddr_d     = adr_d;
        bwe_d       = we_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q    <= StIdle;
      last_q     <= 2'd3;
      id_q       <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      cnt_q      <= '0;
      wbm_ack_o  <= '0;
      wbm_dat_o  <= '0;
      wbs_cyc_o  <= 1'b0;
      wbs_stb_o  <= 1'b0;
      wbs_we_o   <= 1'b0;
      wbs_adr_o  <= '0;
      wbs_dat_o  <= '0;
      bm_memv    <= 1'b0;
      bm_timeout <= 1'b0;
      bm_wbm_id  <= '0;
      bm_addr    <= '0;
      bm_we      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      cnt_q      <= cnt_d;
      wbm_ack_o  <= ack_d;
      wbm_dat_o  <= mdat_d;
      wbs_cyc_o  <= scyc_d;
      wbs_stb_o  <= scyc_d;
      wbs_we_o   <= swe_d;
      wbs_adr_o  <= sadr_d;
      wbs_dat_o  <= sdat_d;
      bm_memv    <= memv_d;
      bm_timeout <= tout_d;
      bm_wbm_id  <= bid_d;
      bm_addr    <= baddr_d;
      bm_we      <= bwe_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with TIMEOUT_LIMIT = 8.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  wbm_cyc = '0;
  logic [3:0]  wbm_stb = '0;
  logic [3:0]  wbm_we = '0;
  logic [63:0] wbm_adr = '0;
  logic [63:0] wbm_dat = '0;
  logic [15:0] wbm_dat_o;
  logic [3:0]  wbm_ack_o;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [15:0] wbs_adr_o, wbs_dat_o;
  logic [15:0] wbs_dat = '0;
  logic        wbs_ack = 1'b0;
  logic        bm_memv, bm_timeout, bm_we;
  logic [1:0]  bm_wbm_id;
  logic [15:0] bm_addr;
  logic [75:0] all_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign all_out = {wbm_ack_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
                    bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we};

  wb_bus_arbiter #(.TIMEOUT_LIMIT(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbm_cyc_i  (wbm_cyc),
    .wbm_stb_i  (wbm_stb),
    .wbm_we_i   (wbm_we),
    .wbm_adr_i  (wbm_adr),
    .wbm_dat_i  (wbm_dat),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_o  (wbm_ack_o),
    .wbs_cyc_o  (wbs_cyc_o),
    .wbs_stb_o  (wbs_stb_o),
    .wbs_we_o   (wbs_we_o),
    .wbs_adr_o  (wbs_adr_o),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_dat_i  (wbs_dat),
    .wbs_ack_i  (wbs_ack),
    .bm_memv    (bm_memv),
    .bm_timeout (bm_timeout),
    .bm_wbm_id  (bm_wbm_id),
    .bm_addr    (bm_addr),
    .bm_we      (bm_we)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters;
    wbm_cyc = '0;
    wbm_stb = '0;
    wbm_we  = '0;
    wbm_adr = '0;
    wbm_dat = '0;
    wbs_ack = 1'b0;
    wbs_dat = '0;
  endtask

  task automatic test_reset;
    wbm_cyc = 4'b0001;
    wbm_stb = 4'b0001;
    wbs_ack = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (all_out !== 76'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    clear_masters();
    rst = 1'b1;
  endtask

  task automatic test_read;
    wbm_cyc[2] = 1'b1;
    wbm_stb[2] = 1'b1;
    wbm_adr[47:32] = 16'h0010;
    tick();
    n_cmp++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o} !== {3'b110, 16'h0010}) begin
      n_bad++;
      $display("FAIL read_slave_req: got %b %h want 110 0010",
               {wbs_cyc_o, wbs_stb_o, wbs_we_o}, wbs_adr_o);
    end
    tick();
    tick();
    n_cmp++;
    if ({wbs_stb_o, wbm_ack_o} !== 5'b1_0000) begin
      n_bad++;
      $display("FAIL read_wait: got stb=%b ack=%b want stb=1 ack=0000", wbs_stb_o, wbm_ack_o);
    end
    wbs_ack = 1'b1;
    wbs_dat = 16'hBEEF;
    tick();
    wbs_ack = 1'b0;
    n_cmp++;
    if ({wbm_ack_o, wbm_dat_o, bm_memv, bm_timeout, wbs_stb_o} !== {4'b0100, 16'hBEEF, 3'b000})
    begin
      n_bad++;
      $display("FAIL read_resp: got ack=%b dat=%h memv=%b tout=%b stb=%b want 0100 BEEF 0 0 0",
               wbm_ack_o, wbm_dat_o, bm_memv, bm_timeout, wbs_stb_o);
    end
    clear_masters();
    tick();
    n_cmp++;
    if (all_out !== 76'd0) begin
      n_bad++;
      $display("FAIL read_ack_one_cycle: got %h want 0", all_out);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] e;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wbm_adr[16*n +: 16] = 16'h0200 + 16'(n);
      wbm_dat[16*n +: 16] = 16'hD000 + 16'(n);
      wbm_we[n] = n[0];
    end
    wbm_cyc = 4'b1111;
    wbm_stb = 4'b1111;
    wbs_ack = 1'b1;
    wbs_dat = 16'h7700;
    for (int g = 0; g < 5; g++) begin
      e = 2'(g % 4);
      tick();
      n_cmp++;
      if ({wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o} !==
          {1'b1, e[0], 16'h0200 + 16'(e), 16'hD000 + 16'(e)}) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got stb=%b we=%b adr=%h dat=%h want master %0d",
                 g, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, e);
      end
      tick();
      n_cmp++;
      if ({wbm_ack_o, wbm_dat_o} !== {4'b0001 << e, 16'h7700}) begin
        n_bad++;
        $display("FAIL rr_ack%0d: got ack=%b dat=%h want ack=%b dat=7700",
                 g, wbm_ack_o, wbm_dat_o, 4'b0001 << e);
      end
      tick();
      n_cmp++;
      if ({wbm_ack_o, wbs_stb_o} !== 5'b0) begin
        n_bad++;
        $display("FAIL rr_idle_gap%0d: got ack=%b stb=%b want 0000 0", g, wbm_ack_o, wbs_stb_o);
      end
    end
    clear_masters();
  endtask

  task automatic test_memv;
    wbm_cyc[1] = 1'b1;
    wbm_stb[1] = 1'b1;
    wbm_we[1] = 1'b1;
    wbm_adr[31:16] = 16'hC000;
    wbm_dat[31:16] = 16'h1111;
    wbs_dat = 16'h2222;
    tick();
`ifdef BUS_ARB_MEMV_EN
    n_cmp++;
    if ({wbm_ack_o, wbm_dat_o, bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we, wbs_cyc_o} !==
        {4'b0010, 16'h0000, 2'b10, 2'd1, 16'hC000, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL memv_event: got ack=%b dat=%h memv=%b tout=%b id=%0d adr=%h we=%b cyc=%b",
               wbm_ack_o, wbm_dat_o, bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we, wbs_cyc_o);
    end
    clear_masters();
    tick();
    n_cmp++;
    if (all_out !== 76'd0) begin
      n_bad++;
      $display("FAIL memv_after: got %h want 0", all_out);
    end
`else
    n_cmp++;
    if ({wbs_cyc_o, wbs_we_o, wbs_adr_o, wbs_dat_o, bm_memv, wbm_ack_o} !==
        {2'b11, 16'hC000, 16'h1111, 1'b0, 4'b0000}) begin
      n_bad++;
      $display("FAIL nomemv_access: got cyc=%b we=%b adr=%h dat=%h memv=%b ack=%b",
               wbs_cyc_o, wbs_we_o, wbs_adr_o, wbs_dat_o, bm_memv, wbm_ack_o);
    end
    wbs_ack = 1'b1;
    tick();
    n_cmp++;
    if ({wbm_ack_o, wbm_dat_o, bm_memv} !== {4'b0010, 16'h2222, 1'b0}) begin
      n_bad++;
      $display("FAIL nomemv_resp: got ack=%b dat=%h memv=%b want 0010 2222 0",
               wbm_ack_o, wbm_dat_o, bm_memv);
    end
    clear_masters();
    tick();
`endif
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    wbm_cyc[3] = 1'b1;
    wbm_stb[3] = 1'b1;
    wbm_adr[63:48] = 16'h0100;
    wbs_dat = 16'h1234;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (!wbs_stb_o) break;
      n++;
      tick();
    end
    n_cmp++;
    if (n !== 9) begin
      n_bad++;
      $display("FAIL tout_stb_cycles: got %0d want 9", n);
    end
    n_cmp++;
    if ({wbm_ack_o, wbm_dat_o, bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we} !==
        {4'b1000, 16'h0000, 2'b01, 2'd3, 16'h0100, 1'b0}) begin
      n_bad++;
      $display("FAIL tout_event: got ack=%b dat=%h memv=%b tout=%b id=%0d adr=%h we=%b",
               wbm_ack_o, wbm_dat_o, bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we);
    end
    clear_masters();
    tick();
    n_cmp++;
    if (all_out !== 76'd0) begin
      n_bad++;
      $display("FAIL tout_after: got %h want 0", all_out);
    end
  endtask

  task automatic test_ack_on_limit;
    wbm_cyc[0] = 1'b1;
    wbm_stb[0] = 1'b1;
    wbm_adr[15:0] = 16'h0040;
    tick();
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (wbs_stb_o !== 1'b1) begin
      n_bad++;
      $display("FAIL limit_still_access: got stb=%b want 1", wbs_stb_o);
    end
    wbs_ack = 1'b1;
    wbs_dat = 16'h5A5A;
    tick();
    n_cmp++;
    if ({wbm_ack_o, wbm_dat_o, bm_timeout} !== {4'b0001, 16'h5A5A, 1'b0}) begin
      n_bad++;
      $display("FAIL limit_resp: got ack=%b dat=%h tout=%b want 0001 5A5A 0",
               wbm_ack_o, wbm_dat_o, bm_timeout);
    end
    clear_masters();
    tick();
    n_cmp++;
    if ({wbm_ack_o, bm_timeout} !== 5'b0) begin
      n_bad++;
      $display("FAIL limit_after: got ack=%b tout=%b want 0000 0", wbm_ack_o, bm_timeout);
    end
  endtask

  task automatic test_reset_mid;
    wbm_cyc[2] = 1'b1;
    wbm_stb[2] = 1'b1;
    wbm_adr[47:32] = 16'h0300;
    tick();
    n_cmp++;
    if ({wbs_stb_o, wbs_adr_o} !== {1'b1, 16'h0300}) begin
      n_bad++;
      $display("FAIL rstmid_access: got stb=%b adr=%h want 1 0300", wbs_stb_o, wbs_adr_o);
    end
    rst = 1'b0;
    wbs_ack = 1'b1;
    tick();
    n_cmp++;
    if (all_out !== 76'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h want 0", all_out);
    end
    rst = 1'b1;
    clear_masters();
    wbm_cyc = 4'b1001;
    wbm_stb = 4'b1001;
    wbm_adr[15:0] = 16'h0A00;
    wbm_adr[63:48] = 16'h0A03;
    tick();
    n_cmp++;
    if ({wbm_ack_o, wbs_stb_o, wbs_adr_o} !== {4'b0000, 1'b1, 16'h0A00}) begin
      n_bad++;
      $display("FAIL rstmid_first_grant: got ack=%b stb=%b adr=%h want 0000 1 0A00",
               wbm_ack_o, wbs_stb_o, wbs_adr_o);
    end
    wbs_ack = 1'b1;
    wbs_dat = 16'h00AA;
    tick();
    n_cmp++;
    if ({wbm_ack_o, wbm_dat_o} !== {4'b0001, 16'h00AA}) begin
      n_bad++;
      $display("FAIL rstmid_resp: got ack=%b dat=%h want 0001 00AA", wbm_ack_o, wbm_dat_o);
    end
    clear_masters();
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_memv();
    test_timeout();
    test_ack_on_limit();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
